serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences the team's single-bit `fulladd` cell over WIDTH-bit operands, one bit per clock, LSB first. It accepts an operand pair through a start/ready handshake and keeps the carry in a register between bits. It reports the WIDTH-bit sum and the final carry with a one-cycle done pulse. It is the area-minimal adder option that sits between a register-file style requester and the shared 1-bit datapath.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/fulladd.sv | 17 +
 rtl/serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial adder controller.
// Build option: SERIAL_ADD_SUB_EN (see serial_add_ctrl) does not change anything here.
package serial_add_pkg;

    // Operand width used when the instantiating block does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states. RUN spends one clock per operand bit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/fulladd.sv
// fulladd: single-bit full adder cell, purely combinational.
// This is the shared 1-bit datapath that serial_add_ctrl sequences.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : fulladd

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. Accepts an operand pair on a
// start/ready handshake, feeds one bit per clock (LSB first) through a single
// fulladd cell, and reports {cout, sum} with a one-cycle done pulse.
// Build option: define SERIAL_ADD_SUB_EN to add the sub port; with sub=1 the
// block computes op_a - op_b (cout=1 means no borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_fa_s;
    logic               w_fa_co;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;

    // Subtraction reuses the adder: a + ~b + 1.
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load     = sub ? ~op_b : op_b;
    assign w_carry_load = sub ? 1'b1 : cin;
`else
    assign w_b_load     = op_b;
    assign w_carry_load = cin;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == CNT_LAST);

    // The one shared 1-bit datapath, fed from the shift register LSBs.
    fulladd u_fulladd (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_co)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the registered state.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand load on accept, then one bit per clock through the adder cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= op_a;
            r_b_sh  <= w_b_load;
            r_carry <= w_carry_load;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            // Result fills from the MSB so that after WIDTH shifts bit 0 sits at sum[0].
            r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_fa_co;
            r_cnt   <= r_cnt + CNT_ONE;
            if (w_last) begin
                r_cout <= w_fa_co;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=13.
// Expected results are queued on each accept edge and compared on each done pulse.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        s8_start = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        s8_cin = 1'b0, s8_sub = 1'b0;
    logic        s8_ready, s8_busy, s8_done, s8_cout;
    logic [7:0]  s8_sum;

    // 13-bit instance
    logic        s13_start = 1'b0;
    logic [12:0] s13_a = '0, s13_b = '0;
    logic        s13_cin = 1'b0, s13_sub = 1'b0;
    logic        s13_ready, s13_busy, s13_done, s13_cout;
    logic [12:0] s13_sum;

    int n_checks = 0;
    int n_errors = 0;
    int acc8 = 0, done8 = 0, acc13 = 0, done13 = 0;
    logic [64:0] q8[$];
    logic [64:0] q13[$];

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (s8_start),
        .op_a  (s8_a),
        .op_b  (s8_b),
        .cin   (s8_cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (s8_sub),
`endif
        .ready (s8_ready),
        .busy  (s8_busy),
        .done  (s8_done),
        .sum   (s8_sum),
        .cout  (s8_cout)
    );

    serial_add_ctrl #(.WIDTH(13)) u_dut13 (
        .clk   (clk),
        .rst   (rst),
        .start (s13_start),
        .op_a  (s13_a),
        .op_b  (s13_b),
        .cin   (s13_cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (s13_sub),
`endif
        .ready (s13_ready),
        .busy  (s13_busy),
        .done  (s13_done),
        .sum   (s13_sum),
        .cout  (s13_cout)
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: cout in bit 64, sum (width w) in the low bits.
    function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s);
        logic [63:0] mask;
        logic [64:0] full;
        logic [63:0] rs;
        logic        rc;
        mask = (64'd1 << w) - 64'd1;
        if (s) begin
            rs = ((a & mask) - (b & mask)) & mask;
            rc = ((a & mask) >= (b & mask));
        end else begin
            full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
            rs   = full[63:0] & mask;
            rc   = full[w];
        end
        return {rc, rs};
    endfunction

    // Scoreboard push on each accept edge (inputs are only driven on negedges).
    always @(posedge clk) begin
        if (!rst && s8_start && s8_ready) begin
            q8.push_back(model(8, 64'(s8_a), 64'(s8_b), s8_cin, s8_sub));
            acc8++;
        end
        if (!rst && s13_start && s13_ready) begin
            q13.push_back(model(13, 64'(s13_a), 64'(s13_b), s13_cin, s13_sub));
            acc13++;
        end
    end

    // Scoreboard pop and compare on each done pulse.
    always @(negedge clk) begin
        if (s8_done) begin
            done8++;
            if (q8.size() == 0) check("done8_without_accept", 65'(q8.size()), 65'd1);
            else check("res8", {s8_cout, 56'd0, s8_sum}, q8.pop_front());
        end
        if (s13_done) begin
            done13++;
            if (q13.size() == 0) check("done13_without_accept", 65'(q13.size()), 65'd1);
            else check("res13", {s13_cout, 51'd0, s13_sum}, q13.pop_front());
        end
    end

    // One 8-bit operation; optionally checks done latency and the ready return.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic s, input bit chk_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!s8_ready && n < 40) begin @(negedge clk); n++; end
        s8_a = a; s8_b = b; s8_cin = c; s8_sub = s; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
        n = 0;
        while (!s8_done && n < 40) begin @(negedge clk); n++; end
        if (chk_lat) check("lat8_done_edges", 65'(n), 65'd8);
        else if (!s8_done) check("done8_timeout", 65'(s8_done), 65'd1);
        @(negedge clk);
        if (chk_lat) begin
            check("ready8_after_done", 65'(s8_ready), 65'd1);
            check("done8_one_cycle", 65'(s8_done), 65'd0);
        end
    endtask

    task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic c, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        while (!s13_ready && n < 40) begin @(negedge clk); n++; end
        s13_a = a; s13_b = b; s13_cin = c; s13_sub = s; s13_start = 1'b1;
        @(negedge clk);
        s13_start = 1'b0;
        n = 0;
        while (!s13_done && n < 40) begin @(negedge clk); n++; end
        if (!s13_done) check("done13_timeout", 65'(s13_done), 65'd1);
        else check("lat13_done_edges", 65'(n), 65'd13);
    endtask

    initial begin
        int n;
        int acc_before;
        logic rs;

        // Reset state
        #1;
        check("rst_ready", 65'(s8_ready), 65'd1);
        check("rst_busy", 65'(s8_busy), 65'd0);
        check("rst_done", 65'(s8_done), 65'd0);
        check("rst_sum_cout", {s8_cout, 56'd0, s8_sum}, 65'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed additions
        op8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b1);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);

        // Back-to-back with start held high
        @(negedge clk);
        acc_before = acc8;
        s8_a = 8'h11; s8_b = 8'h22; s8_cin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_a = 8'h40; s8_b = 8'hC5; s8_cin = 1'b1;
        n = 0;
        while (!s8_done && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        check("b2b_ready", 65'(s8_ready), 65'd1);
        @(negedge clk);
        check("b2b_busy_second", 65'(s8_busy), 65'd1);
        s8_start = 1'b0;
        n = 0;
        while (!s8_done && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        check("b2b_accepts", 65'(acc8 - acc_before), 65'd2);

        // start pulsed during RUN is ignored
        acc_before = acc8;
        s8_a = 8'h0F; s8_b = 8'hF0; s8_cin = 1'b1; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (2) @(negedge clk);
        s8_a = 8'hAA; s8_b = 8'hAA; s8_cin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        n = 0;
        while (!s8_done && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("run_start_ignored", 65'(acc8 - acc_before), 65'd1);

        // Reset during the 4th RUN cycle of 0x12 + 0x34
        s8_a = 8'h12; s8_b = 8'h34; s8_cin = 1'b0; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        q8.delete();
        acc8 = done8;
        check("abort_ready", 65'(s8_ready), 65'd1);
        check("abort_busy", 65'(s8_busy), 65'd0);
        check("abort_done", 65'(s8_done), 65'd0);
        check("abort_sum_cout", {s8_cout, 56'd0, s8_sum}, 65'd0);
        n = done8;
        repeat (12) @(negedge clk);
        check("abort_no_done", 65'(done8 - n), 65'd0);
        rst = 1'b0;
        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
        op8(8'h10, 8'h01, 1'b1, 1'b1, 1'b1);
        op8(8'h00, 8'h01, 1'b0, 1'b1, 1'b1);
`endif

        // Random, both widths
        for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            op8(8'($urandom), 8'($urandom), 1'($urandom), rs, 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            op13(13'($urandom), 13'($urandom), 1'($urandom), rs);
        end

        repeat (3) @(negedge clk);
        check("one_done_per_accept8", 65'(done8), 65'(acc8));
        check("one_done_per_accept13", 65'(done13), 65'(acc13));
        check("queue8_drained", 65'(q8.size()), 65'd0);
        check("queue13_drained", 65'(q13.size()), 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_add_ctrl
